// File: rtl/counter_bcd_multidigit_if.sv
// Control/status bundle for the multi-digit BCD counter.
// The master drives the count controls; the slave (the counter) returns count and flags.
interface counter_bcd_multidigit_if #(
  parameter int NUM_DIGITS = 4
);
  logic                    en;
  logic                    up;
  logic                    clr;
  logic                    load;
  logic [4*NUM_DIGITS-1:0] load_val;
  logic [4*NUM_DIGITS-1:0] bcd;
  logic                    tc;
  logic                    load_err;

  modport master (
    output en, up, clr, load, load_val,
    input  bcd, tc, load_err
  );

  modport slave (
    input  en, up, clr, load, load_val,
    output bcd, tc, load_err
  );
endinterface

// File: rtl/counter_bcd_multidigit.sv
// Parametrised multi-digit BCD up/down counter with clear, clamped parallel load
// and wrap/saturate terminal handling; tc is combinational so instances can cascade.
module counter_bcd_multidigit #(
  parameter int NUM_DIGITS = 4,
  parameter int WRAP       = 1
) (
  input logic                      clk,
  input logic                      rst_n,
  counter_bcd_multidigit_if.slave  bus
);
  localparam int W = 4*NUM_DIGITS;

  logic [W-1:0]          r_bcd;
  logic                  r_load_err;
  logic [W-1:0]          w_bcd_nxt;
  logic [W-1:0]          w_load_clamped;
  logic                  w_clamp_any;
  logic                  w_all9;
  logic                  w_all0;
  logic                  w_at_term;
  logic                  w_carry;
  logic [3:0]            w_digit;

  // Whole carry/borrow chain resolves combinationally: a digit steps only
  // when every lower digit is at its roll-over value for the current direction.
  always_comb begin
    w_bcd_nxt = r_bcd;
    w_carry   = 1'b1;
    w_digit   = 4'd0;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      w_digit = r_bcd[4*i +: 4];
      if (w_carry) begin
        if (bus.up) w_bcd_nxt[4*i +: 4] = (w_digit == 4'd9) ? 4'd0 : w_digit + 4'd1;
        else        w_bcd_nxt[4*i +: 4] = (w_digit == 4'd0) ? 4'd9 : w_digit - 4'd1;
      end
      w_carry = w_carry & (bus.up ? (w_digit == 4'd9) : (w_digit == 4'd0));
    end
  end

  always_comb begin
    w_load_clamped = '0;
    w_clamp_any    = 1'b0;
    w_all9         = 1'b1;
    w_all0         = 1'b1;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (bus.load_val[4*i +: 4] > 4'd9) begin
        w_load_clamped[4*i +: 4] = 4'd9;
        w_clamp_any              = 1'b1;
      end else begin
        w_load_clamped[4*i +: 4] = bus.load_val[4*i +: 4];
      end
      w_all9 = w_all9 & (r_bcd[4*i +: 4] == 4'd9);
      w_all0 = w_all0 & (r_bcd[4*i +: 4] == 4'd0);
    end
  end

  assign w_at_term = bus.up ? w_all9 : w_all0;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_bcd      <= '0;
      r_load_err <= 1'b0;
    end else if (bus.clr) begin
      r_bcd      <= '0;
      r_load_err <= 1'b0;
    end else if (bus.load) begin
      r_bcd      <= w_load_clamped;
      r_load_err <= w_clamp_any;
    end else begin
      r_load_err <= 1'b0;
      // Saturating variant parks at the terminal instead of rolling over.
      if (bus.en && !((WRAP == 0) && w_at_term)) r_bcd <= w_bcd_nxt;
    end
  end

  assign bus.bcd      = r_bcd;
  assign bus.load_err = r_load_err;
  assign bus.tc       = bus.en & ~bus.clr & ~bus.load & w_at_term;
endmodule
